// File: rtl/ab_stop_seq_pkg.sv
// rtl/ab_stop_seq_pkg.sv - shared state, offset type and default limits for the start/a/b/stop generator
`timescale 1ns/1ps
package ab_stop_seq_pkg;

  localparam int OFF_W_D    = 2;
  localparam int A_MIN_D    = 1;
  localparam int A_MAX_D    = 2;
  localparam int STOP_MIN_D = 2;
  localparam int STOP_MAX_D = 3;

  typedef logic [OFF_W_D-1:0] off_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WIN   = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ab_stop_seq_gen.sv
// rtl/ab_stop_seq_gen.sv - start/a/b/stop transaction generator; AB_STOP_SEQ_GEN_ERR_INJ_EN generates illegal offsets
`timescale 1ns/1ps
module ab_stop_seq_gen
  import ab_stop_seq_pkg::*;
#(
  parameter int OFF_W    = OFF_W_D,
  parameter int A_MIN    = A_MIN_D,
  parameter int A_MAX    = A_MAX_D,
  parameter int STOP_MIN = STOP_MIN_D,
  parameter int STOP_MAX = STOP_MAX_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [OFF_W-1:0] a_off,
  input  logic [OFF_W-1:0] stop_off,
  output logic             start,
  output logic             b,
  output logic             a,
  output logic             stop,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  seq_state_e       state, state_n;
  logic [OFF_W-1:0] cnt, cnt_n;
  logic [OFF_W-1:0] a_lat, stop_lat, end_lat;
  logic             legal, take, accept, reject;

  // Widen to 32 bits so range checks against the int limits stay non-constant.
  assign legal = (32'(a_off) >= A_MIN) && (32'(a_off) <= A_MAX) &&
                 (32'(stop_off) >= STOP_MIN) && (32'(stop_off) <= STOP_MAX) &&
                 (a_off == stop_off);

`ifdef AB_STOP_SEQ_GEN_ERR_INJ_EN
  assign take = (a_off != '0) && (stop_off != '0);
`else
  assign take = legal;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (take) begin
            accept  = 1'b1;
            state_n = START;
            cnt_n   = '0;
          end else begin
            reject = 1'b1;
          end
        end
      end
      START: begin
        state_n = WIN;
        cnt_n   = '0;
      end
      WIN: begin
        if (cnt == end_lat) state_n = DONE;
        else                cnt_n   = cnt + 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each lines up with its cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      a_lat    <= '0;
      stop_lat <= '0;
      end_lat  <= '0;
      start    <= 1'b0;
      b        <= 1'b0;
      a        <= 1'b0;
      stop     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cnt <= cnt_n;
      if (accept) begin
        a_lat    <= a_off;
        stop_lat <= stop_off;
        end_lat  <= (a_off > stop_off) ? a_off : stop_off;
      end
      start   <= (state_n == START);
      b       <= (state_n == WIN);
      a       <= (state_n == WIN) && (cnt_n == a_lat);
      stop    <= (state_n == WIN) && (cnt_n == stop_lat);
      busy    <= (state_n != IDLE);
      done    <= (state_n == DONE);
      cfg_err <= reject || (accept && !legal);
    end
  end

endmodule

// File: doc/ab_stop_seq_gen.md
# ab_stop_seq_gen

Stimulus-generating stage that drives the `start`/`a`/`b`/`stop` protocol consumed by the intersect-checking block downstream. On each accepted request it emits a one-cycle `start` pulse. It then emits a `b` window in which `a` and `stop` fire at programmed offsets. A legal transaction satisfies `$rose(start) |=> (##[1:2] a) intersect (b ##[2:3] stop)`. Illegal offset programs are rejected, or with negative testing compiled in, generated deliberately.

## Interface
Parameters:
- `OFF_W`, default 2: width of the offset inputs.
- `A_MIN`, default 1: minimum `a` offset.
- `A_MAX`, default 2: maximum `a` offset.
- `STOP_MIN`, default 2: minimum `stop` offset.
- `STOP_MAX`, default 3: maximum `stop` offset.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, in, 1: sole clock, posedge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req`, in, 1: request a transaction; sampled only in IDLE.
- `a_off`, in, OFF_W: cycles from first `b` cycle to the `a` pulse.
- `stop_off`, in, OFF_W: cycles from first `b` cycle to the `stop` pulse.
- `start`, out, 1: one-cycle start pulse.
- `b`, out, 1: transaction window.
- `a`, out, 1: one-cycle pulse.
- `stop`, out, 1: one-cycle pulse.
- `busy`, out, 1: high from the `start` cycle through the `done` cycle.
- `done`, out, 1: one-cycle completion pulse.
- `cfg_err`, out, 1: one-cycle pulse when an illegal request is rejected.

## Operation
- FSM states: IDLE, START, WIN, DONE.
- All outputs are registered. All outputs reset to 0, and the state resets to IDLE.
- A request is legal when all of the following hold:
  - `A_MIN ≤ a_off ≤ A_MAX`
  - `STOP_MIN ≤ stop_off ≤ STOP_MAX`
  - `a_off == stop_off` (intersect requires a common end point)
- IDLE, `req`=1 and legal: latch `a_off` and `stop_off`, clear `cnt`, go to START.
- IDLE, `req`=1 and illegal: pulse `cfg_err` next cycle and stay in IDLE.
- START: `start`=1 and `busy`=1. Go to WIN.
- WIN:
  - `b`=1 every cycle; `cnt` increments from 0.
  - `a`=1 exactly when `cnt == a_off`; `stop`=1 exactly when `cnt == stop_off`.
  - `end = max(a_off, stop_off)`. When `cnt == end`, go to DONE.
- DONE: `done`=1 and `b`=0. Return to IDLE.
- `req` is ignored outside IDLE; no queueing.
- `start` is never high in two consecutive cycles. There is at least one low cycle between `start` pulses, which guarantees a fresh `$rose`.
- Reset asserted mid-transaction: all outputs drop to 0 asynchronously, the FSM goes to IDLE, and the latched offsets are discarded.

## Timing
- C0: `req` sampled.
- C1: `start`.
- C2: first `b` cycle (`cnt`=0).
- C2+`a_off`: `a`.
- C2+`stop_off`: `stop`.
- C3+end: `done`.
- Legal transaction latency from `req` to `done`: end+3 cycles. For example, offset 2 gives `done` at C5.
- Earliest next accepted `req` is the cycle after `done`.
- `cfg_err` latency is 1 cycle after `req`.

## Configuration
- Macro: `AB_STOP_SEQ_GEN_ERR_INJ_EN`.
- When defined:
  - Illegal-but-in-width offsets are still generated for negative testing of the downstream checker.
  - Offset 0 remains rejected.
  - `cfg_err` still pulses, in the `start` cycle, to flag an intentional violation.
- When undefined: illegal requests are rejected as described in Operation.

## Structure
- Package `ab_stop_seq_pkg` holds:
  - the state enum `seq_state_e` (IDLE, START, WIN, DONE);
  - the `off_t` typedef, `logic [OFF_W-1:0]`;
  - the default limit constants `A_MIN_D`, `A_MAX_D`, `STOP_MIN_D`, `STOP_MAX_D`.
- Single module with no sub-module; the offset counter is inline.

## Test plan
- Reset, then `req`=1 with `a_off`=2, `stop_off`=2 → `start` at C1, `b` for C2–C4, `a` and `stop` both at C4, `done` at C5; downstream p1 passes.
- `a_off`=1, `stop_off`=3 (macro off) → `cfg_err` at C1; no `start`, `b`, `a` or `stop`; `busy` stays 0.
- `a_off`=3, `stop_off`=3 with macro on → `a` and `stop` at C5, `cfg_err` at C1; downstream p1 fails at C5.
- `req` held high continuously with offsets 2/2 → `start` pulses separated by 5 cycles; `start` never high on consecutive cycles.
- Assert `rst` at C3 of a 2/2 transaction → all outputs 0 immediately; the next `req` after reset release starts a clean transaction.
- `req` pulsed during WIN → ignored; exactly one `done` per accepted request.
